// File: rtl/fpr_cdb_arbiter_pkg.sv
// Shared CDB types plus the FPR CDB arbiter configuration.
// Unit order on the FPR CDB: 0 fdiv, 1 fmul, 2 fadd, 3 fsqrt.
package fpr_cdb_arbiter_pkg;

    localparam int ROB_WIDTH = 6;

    typedef struct packed {
        logic                 valid;
        logic [ROB_WIDTH-1:0] tag;
        logic [31:0]          data;
    } cdb_t;

    localparam int FPR_CDB_N_REQ   = 4;
    localparam int FPR_CDB_MAX_LAT = 4;

    localparam int FDIV_LAT  = 0;
    localparam int FSQRT_LAT = 0;
    localparam int FADD_LAT  = 2;
    localparam int FMUL_LAT  = 1;

    localparam logic [FPR_CDB_N_REQ-1:0][31:0] FPR_CDB_LAT = {
        32'(FSQRT_LAT), 32'(FADD_LAT), 32'(FMUL_LAT), 32'(FDIV_LAT)
    };

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or after rr.
// Shared with the integer CDB arbiter.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] rr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] win
);

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((32'(rr) + 32'(k)) % 32'(N));
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        gnt[win] = found;
    end

endmodule

// File: rtl/fpr_cdb_arbiter.sv
// FPR CDB arbiter: grants one unit per cycle into a free fixed-latency
// result slot, samples its data LAT cycles later and broadcasts it.
module fpr_cdb_arbiter
    import fpr_cdb_arbiter_pkg::*;
#(
    parameter int                     N_REQ   = 4,
    parameter int                     MAX_LAT = 4,
    parameter logic [N_REQ-1:0][31:0] LAT     = '0
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [N_REQ-1:0]                    req_valid,
    output logic [N_REQ-1:0]                    req_ready,
    input  logic [N_REQ-1:0][ROB_WIDTH-1:0]     req_tag,
    input  logic [N_REQ-1:0][31:0]              res_data,
    output cdb_t                                fpr_cdb
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int LW = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;

    logic [MAX_LAT:0]                busy, busy_n;
    logic [MAX_LAT:0][IW-1:0]        slot_src, src_n;
    logic [MAX_LAT:0][ROB_WIDTH-1:0] slot_tag, tag_n;
    logic [IW-1:0]                   rr, rr_n;
    logic [N_REQ-1:0][LW-1:0]        lat_of;
    logic [N_REQ-1:0]                elig, gnt;
    logic [IW-1:0]                   win;
    logic [LW-1:0]                   gnt_lat;
    logic                            any_gnt;
    cdb_t                            cdb_n;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            lat_of[i] = LW'(LAT[i]);
            elig[i]   = req_valid[i] && !busy[lat_of[i]];
        end
    end

    rr_arbiter #(.N(N_REQ)) u_rr (
        .elig (elig),
        .rr   (rr),
        .gnt  (gnt),
        .win  (win)
    );

    assign any_gnt   = |gnt;
    assign gnt_lat   = lat_of[win];
    assign req_ready = reset_n ? gnt : '0;

    always_comb begin
        busy_n      = busy >> 1;
        src_n       = slot_src >> IW;
        tag_n       = slot_tag >> ROB_WIDTH;
        rr_n        = rr;
        cdb_n       = fpr_cdb;
        cdb_n.valid = 1'b0;
        if (any_gnt) begin
            rr_n = (win == IW'(N_REQ - 1)) ? '0 : win + IW'(1);
        end
        // Slot L lands at index L-1 once this cycle's shift is applied.
        if (any_gnt && gnt_lat != '0) begin
            busy_n[gnt_lat - LW'(1)] = 1'b1;
            src_n[gnt_lat - LW'(1)]  = win;
            tag_n[gnt_lat - LW'(1)]  = req_tag[win];
        end
        if (busy[0]) begin
            cdb_n = '{valid: 1'b1, tag: slot_tag[0],
                      data: res_data[slot_src[0]]};
        end else if (any_gnt && gnt_lat == '0) begin
            cdb_n = '{valid: 1'b1, tag: req_tag[win],
                      data: res_data[win]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy     <= '0;
            slot_src <= '0;
            slot_tag <= '0;
            rr       <= '0;
            fpr_cdb  <= '0;
        end else begin
            busy     <= busy_n;
            slot_src <= src_n;
            slot_tag <= tag_n;
            rr       <= rr_n;
            fpr_cdb  <= cdb_n;
        end
    end

endmodule

// File: tb/tb_fpr_cdb_arbiter.sv
// Bench for fpr_cdb_arbiter: an all-L=0 instance and the mixed-latency
// FPR configuration, directed vectors plus a scoreboarded random soak.
module tb_fpr_cdb_arbiter;
    import fpr_cdb_arbiter_pkg::*;

    localparam int N = FPR_CDB_N_REQ;

    logic clk = 1'b0;
    logic reset_n;

    logic [N-1:0]                z_valid, z_ready;
    logic [N-1:0][ROB_WIDTH-1:0] z_tag;
    logic [N-1:0][31:0]          z_data;
    cdb_t                        z_cdb;

    logic [N-1:0]                m_valid, m_ready;
    logic [N-1:0][ROB_WIDTH-1:0] m_tag;
    logic [N-1:0][31:0]          m_data;
    cdb_t                        m_cdb;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    fpr_cdb_arbiter #(
        .N_REQ   (N),
        .MAX_LAT (FPR_CDB_MAX_LAT)
    ) u_zero (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (z_valid),
        .req_ready (z_ready),
        .req_tag   (z_tag),
        .res_data  (z_data),
        .fpr_cdb   (z_cdb)
    );

    fpr_cdb_arbiter #(
        .N_REQ   (N),
        .MAX_LAT (FPR_CDB_MAX_LAT),
        .LAT     (FPR_CDB_LAT)
    ) u_mix (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (m_valid),
        .req_ready (m_ready),
        .req_tag   (m_tag),
        .res_data  (m_data),
        .fpr_cdb   (m_cdb)
    );

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] cdb64(input logic v,
                                          input logic [ROB_WIDTH-1:0] t,
                                          input logic [31:0] d);
        cdb_t c;
        c = '{valid: v, tag: t, data: d};
        return 64'(c);
    endfunction

    function automatic logic [31:0] fdat(input int t, input int u);
        return 32'(t * 7 + u * 1000003) ^ 32'hA5A5_0000;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        z_valid = '0;
        m_valid = '0;
        step();
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit                   v;
        logic [ROB_WIDTH-1:0] tag;
        logic [31:0]          data;
    } slot_t;

    slot_t        ring [16];
    int           lat [N];
    int           order [5];
    int           rr_m, w, s, ps, u, max_wait;
    int           waitc [N];
    logic [N-1:0] exp_rdy;

    initial begin
        lat   = '{FDIV_LAT, FMUL_LAT, FADD_LAT, FSQRT_LAT};
        order = '{0, 1, 2, 3, 0};
        reset_n = 1'b0;
        z_valid = '1;
        m_valid = '1;
        z_tag   = '0;
        m_tag   = '0;
        z_data  = '0;
        m_data  = '0;
        @(negedge clk);

        // Reset held two cycles with every request raised.
        #1;
        check("rst_ready_z", 64'(z_ready), 64'(0));
        check("rst_ready_m", 64'(m_ready), 64'(0));
        step();
        step();
        check("rst_ready_z2", 64'(z_ready), 64'(0));
        check("rst_cdb_z", 64'(z_cdb), 64'(0));
        check("rst_cdb_m", 64'(m_cdb), 64'(0));

        // Single L=0 grant, broadcast next cycle.
        do_reset();
        z_valid   = 4'b0001;
        z_tag[0]  = 6'd5;
        z_data[0] = 32'h3F80_0000;
        #1;
        check("single_ready", 64'(z_ready), 64'(4'b0001));
        step();
        z_valid = '0;
        check("single_cdb", 64'(z_cdb), cdb64(1'b1, 6'd5, 32'h3F80_0000));
        step();
        check("single_idle", 64'(z_cdb.valid), 64'(0));

        // Round robin over four L=0 units, one broadcast per cycle.
        do_reset();
        for (int i = 0; i < N; i++) begin
            z_tag[i]  = ROB_WIDTH'(10 + i);
            z_data[i] = 32'h100 + 32'(i);
        end
        z_valid = '1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("rr_ready", 64'(z_ready), 64'(4'b0001 << order[c]));
            step();
            check("rr_cdb", 64'(z_cdb),
                  cdb64(1'b1, ROB_WIDTH'(10 + order[c]),
                        32'h100 + 32'(order[c])));
        end
        z_valid = '0;

        // Collision: fadd (L=2) at t blocks fmul (L=1) at t+1.
        do_reset();
        m_valid  = 4'b0100;
        m_tag[2] = 6'd7;
        #1;
        check("col_ready_t", 64'(m_ready), 64'(4'b0100));
        step();
        m_valid  = 4'b0010;
        m_tag[1] = 6'd9;
        #1;
        check("col_ready_t1", 64'(m_ready), 64'(0));
        step();
        m_data[2] = 32'hAAAA_0002;
        #1;
        check("col_ready_t2", 64'(m_ready), 64'(4'b0010));
        check("col_idle_t2", 64'(m_cdb.valid), 64'(0));
        step();
        m_valid   = '0;
        m_data[1] = 32'hBBBB_0001;
        m_data[2] = '0;
        check("col_cdb_t3", 64'(m_cdb), cdb64(1'b1, 6'd7, 32'hAAAA_0002));
        step();
        m_data[1] = '0;
        check("col_cdb_t4", 64'(m_cdb), cdb64(1'b1, 6'd9, 32'hBBBB_0001));
        step();
        check("col_idle_t5", 64'(m_cdb.valid), 64'(0));

        // Reset mid-flight drops the fadd result and rewinds rr.
        do_reset();
        m_valid  = 4'b0100;
        m_tag[2] = 6'd3;
        #1;
        check("flush_ready", 64'(m_ready), 64'(4'b0100));
        step();
        m_valid = '0;
        reset_n = 1'b0;
        step();
        reset_n   = 1'b1;
        m_data[2] = 32'hDEAD_BEEF;
        check("flush_idle_t2", 64'(m_cdb.valid), 64'(0));
        step();
        m_data[2] = '0;
        check("flush_idle_t3", 64'(m_cdb.valid), 64'(0));
        step();
        check("flush_idle_t4", 64'(m_cdb.valid), 64'(0));
        m_valid = '1;
        #1;
        check("flush_rr0", 64'(m_ready), 64'(4'b0001));
        m_valid = '0;

        // Random soak on the mixed-latency configuration.
        do_reset();
        foreach (ring[i]) ring[i].v = 1'b0;
        foreach (waitc[i]) waitc[i] = 0;
        rr_m     = 0;
        max_wait = 0;
        for (int t = 0; t < 10000; t++) begin
            ps = (t + 15) % 16;
            if (ring[ps].v)
                check("soak_cdb", 64'(m_cdb),
                      cdb64(1'b1, ring[ps].tag, ring[ps].data));
            else
                check("soak_idle", 64'(m_cdb.valid), 64'(0));
            ring[ps].v = 1'b0;
            m_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                m_tag[i]  = ROB_WIDTH'($urandom);
                m_data[i] = fdat(t, i);
            end
            #1;
            w = -1;
            for (int k = 0; k < N; k++) begin
                u = (rr_m + k) % N;
                if (w < 0 && m_valid[u] && !ring[(t + lat[u]) % 16].v)
                    w = u;
            end
            exp_rdy = (w >= 0) ? N'(1 << w) : '0;
            check("soak_ready", 64'(m_ready), 64'(exp_rdy));
            if (w >= 0) begin
                s = (t + lat[w]) % 16;
                check("soak_collide", 64'(ring[s].v), 64'(0));
                ring[s].v    = 1'b1;
                ring[s].tag  = m_tag[w];
                ring[s].data = fdat(t + lat[w], w);
                rr_m = (w + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (m_valid[i] && w != i) waitc[i]++;
                else waitc[i] = 0;
                if (waitc[i] > max_wait) max_wait = waitc[i];
            end
            step();
        end
        m_valid = '0;
        check("soak_starve", 64'(max_wait <= N * (FPR_CDB_MAX_LAT + 1)),
              64'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fpr_cdb_arbiter.md
# fpr_cdb_arbiter

Responder end of the FPR common data bus request handshake. Up to N_REQ floating-point execution units (fadd/fmul, fdiv/fsqrt, …) raise `req_valid` with a ROB tag. The arbiter grants one request per cycle, round-robin, and only when that unit's fixed-latency result slot on the bus is still free. It then captures the unit's result data `LAT` cycles later and broadcasts it as a registered `cdb_t` on `fpr_cdb` to the reservation stations, the register file and the ROB.

## Interface
Parameters:
- `N_REQ`, 4, number of requesting units
- `MAX_LAT`, 4, largest permitted unit latency in cycles
- `LAT`, all zeros, per-unit latency array `[N_REQ-1:0]`, each value in 0..MAX_LAT; fixed at elaboration

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `req_valid`  in  N_REQ  unit i has a result ready to schedule (the `valid` side of the unit's `req_if`)
- `req_ready`  out  N_REQ  grant to unit i; the unit dispatches when `req_valid[i] && req_ready[i]`
- `req_tag`  in  N_REQ×ROB_WIDTH  ROB tag of unit i's pending result, valid with `req_valid[i]`
- `res_data`  in  N_REQ×32  result of unit i, sampled exactly `LAT[i]` cycles after its grant
- `fpr_cdb`  out  cdb_t  registered broadcast: `valid`, `tag[ROB_WIDTH]`, `data[32]`

## Operation
- Reservation state:
  - `busy[MAX_LAT:0]`: `busy[k]` means the sample slot k cycles from now is taken.
  - `slot_src[k]` (unit index) and `slot_tag[k]` accompany each `busy[k]`.
- Eligibility: unit i is eligible when `req_valid[i] && !busy[LAT[i]]`.
- Arbitration:
  - One winner per cycle, round-robin starting at pointer `rr`.
  - `req_ready[w]=1` for the winner only; all other `req_ready` bits are 0.
  - `rr` advances to `w+1` mod N_REQ after a grant; it holds when there is no grant.
  - `req_ready` is combinational from the current state and `req_valid`. It must not depend on `res_data`.
- Shift every cycle: `busy[k] <= busy[k+1]`, and the same for `slot_src` and `slot_tag`. `busy[MAX_LAT] <= 0`.
- Grant insertion:
  - On a grant to w with `LAT[w]=L≥1`, write slot L-1 (post-shift position) with `{1, w, req_tag[w]}`.
  - `LAT=0` uses the current-cycle path: the grant and the data sample happen in the same cycle.
- Sample: in a cycle where the current slot is occupied, the next `fpr_cdb` is `{1, slot_tag, res_data[slot_src]}`. The current slot is occupied when `busy[0]`, or on an L=0 grant. Otherwise `fpr_cdb.valid <= 0`.
- `fpr_cdb.tag` and `fpr_cdb.data` are don't-care when `valid=0`. They are held (not X-forced) to ease waveform reading.
- Invariant: at most one sample per cycle. The eligibility check makes a slot collision impossible; the bench asserts it.

## Timing
- Reset (`reset_n=0` at an edge):
  - `busy` cleared, `rr=0`, `fpr_cdb.valid=0`, `fpr_cdb.tag=0`, `fpr_cdb.data=0`.
  - `req_ready` is all zeros while `reset_n=0`.
- Reset mid-operation: all in-flight reservations are discarded and no broadcast follows. Reset is also the mispredict flush, so dropping those results is correct.
- Latency: grant at cycle t with latency L → data sampled at t+L → `fpr_cdb.valid=1` during cycle t+L+1.
- Throughput: one broadcast per cycle with no bubble when latencies allow, e.g. two L=0 units alternating.
- Grant at t to L=2, then a request at t+1 from an L=1 unit: blocked at t+1, since both would land on t+2. It becomes eligible at t+2.
- The arbiter never stalls a granted result. Units must produce valid `res_data` at exactly t+L.
- `req_valid` may drop without a grant; no state is changed by a withdrawn request.

## Structure
- Already in the shared package: `cdb_t`, `ROB_WIDTH`.
- Add to the package: `FPR_CDB_N_REQ` and the per-unit latency constants (fdiv/fsqrt = 0, fadd = 2, fmul = 1). The top level and the bench share these.
- Sub-module `rr_arbiter #(N)`:
  - Inputs: eligible mask and `rr` pointer.
  - Outputs: one-hot grant and winner index.
  - Purely combinational; it is reused by the integer CDB arbiter.

## Test plan
- Reset: hold `reset_n=0` for 2 cycles with all `req_valid=1` → `req_ready=0`, `fpr_cdb.valid=0`, `tag=0`, `data=0`.
- Single L=0 unit 0 (`tag=5`, `res_data=0x3F800000`) → `req_ready[0]=1` at t; at t+1 `fpr_cdb={1,5,0x3F800000}`.
- Round-robin with all four L=0 units valid continuously → grant order 0,1,2,3,0; `fpr_cdb.valid=1` every cycle; tags follow the grant order.
- Collision: unit 2 (L=2) granted at t, unit 1 (L=1) valid from t+1:
  - `req_ready[1]=0` at t+1 and `=1` at t+2.
  - Broadcasts at t+3 (unit 2) and t+4 (unit 1).
- Reset mid-flight: grant unit 2 (L=2) at t, `reset_n=0` at t+1 → no `fpr_cdb.valid` at t+3; `rr=0` afterwards.
- Random soak: 10k cycles of random `req_valid` across mixed latencies. Checks:
  - Each granted tag is broadcast exactly once, at grant+L+1.
  - Never two samples in one cycle.
  - No starvation beyond N_REQ×(MAX_LAT+1) cycles.
